// File: rtl/audio_dc_filter.sv
// -----------------------------------------------------------------------------
// audio_dc_filter
//
// Sits between the arcade core's raw unsigned mono audio and the framework's
// signed 16-bit audio outputs. For each strobed sample it re-centres the sample
// to signed, removes the DC offset with a first-order IIR high-pass (DC
// blocker), applies a 4-step attenuation, saturates to OUT_W bits and can force
// the output to zero (mute, used for pause).
//
// Pipeline (ce_sample sampled at the edge ending cycle N):
//   S1 regs (valid in N+1) : x = audio_in - midpoint, d = x - x_prev
//   S2 regs (valid in N+2) : acc <= acc + (d << K) - (acc >>> K)
//   S3 regs (valid in N+3) : audio_out, out_valid
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   asynchronous, active-high; clears all state
//   ce_sample  in   one-cycle strobe, audio_in valid on this cycle
//   audio_in   in   IN_W-bit unsigned offset-binary sample
//   vol        in   attenuation: 0/1/2/3 = 0/-6/-12/-18 dB (sampled in S3)
//   mute       in   forces audio_out to 0 (sampled in S3); filter keeps running
//   audio_out  out  OUT_W-bit signed filtered sample, held between updates
//   out_valid  out  one-cycle pulse when audio_out updates
//   overrun    out  sticky; a strobe arrived while the pipeline was busy
// -----------------------------------------------------------------------------
module audio_dc_filter #(
   parameter int IN_W  = 13,
   parameter int OUT_W = 16,
   parameter int K     = 8
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    ce_sample,
   input  logic [IN_W-1:0]         audio_in,
   input  logic [1:0]              vol,
   input  logic                    mute,
   output logic signed [OUT_W-1:0] audio_out,
   output logic                    out_valid,
   output logic                    overrun
);

   localparam int X_W   = IN_W + 1;
   localparam int D_W   = IN_W + 2;
   localparam int ACC_W = IN_W + K + 3;
   localparam int S_W   = ACC_W + (OUT_W - IN_W);

   localparam logic [X_W-1:0] MIDPOINT = X_W'(1) << (IN_W - 1);

   localparam int SAT_MAX_I = 2 ** (OUT_W - 1) - 1;
   localparam logic signed [S_W-1:0] SAT_MAX = S_W'(SAT_MAX_I);
   localparam logic signed [S_W-1:0] SAT_MIN = S_W'(-SAT_MAX_I - 1);

   // Pipeline state
   logic                    s1_v_q, s2_v_q;
   logic signed [X_W-1:0]   x_prev_q, x_prev_d;
   logic signed [D_W-1:0]   d_q, d_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [OUT_W-1:0] audio_out_q, audio_out_d;
   logic                    out_valid_q;
   logic                    overrun_q;

   logic                    busy;
   logic                    accept;
   logic signed [X_W-1:0]   x;
   logic signed [ACC_W-1:0] d_shifted;
   logic signed [S_W-1:0]   acc_ext;
   logic signed [S_W-1:0]   scaled;

   // The busy window covers the strobe cycle through S3: a new strobe is
   // only legal once the previous sample has produced its output pulse.
   assign busy   = s1_v_q | s2_v_q | out_valid_q;
   assign accept = ce_sample & ~busy;

   // S1: re-centre and first difference. Subtracting the midpoint in X_W bits
   // yields the two's complement value directly.
   always_comb begin
      x        = $signed({1'b0, audio_in} - MIDPOINT);
      d_d      = $signed({x[X_W-1], x}) - $signed({x_prev_q[X_W-1], x_prev_q});
      x_prev_d = accept ? x : x_prev_q;
   end

   // S2: integrator with leak. The leak uses an arithmetic shift, so it
   // rounds toward minus infinity.
   always_comb begin
      d_shifted = $signed({{(ACC_W - D_W){d_q[D_W-1]}}, d_q}) <<< K;
      acc_d     = s1_v_q ? (acc_q + d_shifted - (acc_q >>> K)) : acc_q;
   end

   // S3: scale to output width, attenuate, saturate, mute.
   always_comb begin
      acc_ext     = $signed({{(OUT_W - IN_W){acc_q[ACC_W-1]}}, acc_q});
      scaled      = ((acc_ext >>> K) <<< (OUT_W - IN_W)) >>> vol;
      audio_out_d = audio_out_q;
      if (s2_v_q) begin
         if (mute)
            audio_out_d = '0;
         else if (scaled > SAT_MAX)
            audio_out_d = OUT_W'(SAT_MAX);
         else if (scaled < SAT_MIN)
            audio_out_d = OUT_W'(SAT_MIN);
         else
            audio_out_d = scaled[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         x_prev_q    <= '0;
         d_q         <= '0;
         acc_q       <= '0;
         audio_out_q <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         s1_v_q      <= accept;
         s2_v_q      <= s1_v_q;
         out_valid_q <= s2_v_q;
         x_prev_q    <= x_prev_d;
         if (accept)
            d_q <= d_d;
         acc_q       <= acc_d;
         audio_out_q <= audio_out_d;
         if (ce_sample && busy)
            overrun_q <= 1'b1;
      end
   end

   assign audio_out = audio_out_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule
